// File: rtl/hilo_muldiv.sv
// Multicycle unsigned multiply/divide unit owning the HI/LO register pair.
// Shift-add multiply and restoring divide, one bit per clock; results land on the DONE edge.
module hilo_muldiv #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op,
    input  logic [n-1:0] in0,
    input  logic [n-1:0] in1,
    output logic         busy,
    output logic         done,
    output logic         div_zero,
    output logic [n-1:0] hi,
    output logic [n-1:0] lo
);

    localparam int CW = $clog2(n) + 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [n-1:0]     opb_q, opb_d;
    logic [2*n-1:0]   acc_q, acc_d;
    logic [n-1:0]     hi_q, hi_d;
    logic [n-1:0]     lo_q, lo_d;
    logic             dz_q, dz_d;

    logic [n:0]       mul_sum;
    logic [n:0]       rem_sh;
    logic [n-1:0]     rem_sub;
    logic             rem_ge;
    logic             last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;

        last    = (cnt_q == CW'(n - 1));
        // acc holds {partial product, remaining multiplier bits} during MUL
        mul_sum = {1'b0, acc_q[2*n-1:n]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        // acc holds {remainder, remaining dividend / quotient bits} during DIV;
        // a successful subtract always fits in n bits since the result is below the divisor
        rem_sh  = acc_q[2*n-1:n-1];
        rem_ge  = (rem_sh >= {1'b0, opb_q});
        rem_sub = rem_sh[n-1:0] - opb_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    opb_d = in1;
                    acc_d = {{n{1'b0}}, in0};
                    dz_d  = 1'b0;
                    if (!op) begin
                        state_d = MUL;
                    end else if (in1 == '0) begin
                        dz_d    = 1'b1;
                        hi_d    = in0;
                        lo_d    = '1;
                        state_d = DONE;
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            MUL: begin
                acc_d = {mul_sum, acc_q[n-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    hi_d    = acc_d[2*n-1:n];
                    lo_d    = acc_d[n-1:0];
                    state_d = DONE;
                end
            end
            DIV: begin
                if (rem_ge) begin
                    acc_d = {rem_sub, acc_q[n-2:0], 1'b1};
                end else begin
                    acc_d = {rem_sh[n-1:0], acc_q[n-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    hi_d    = acc_d[2*n-1:n];
                    lo_d    = acc_d[n-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q == MUL) || (state_q == DIV);
    assign done     = (state_q == DONE);
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv (n = 32) with hand-computed expectations.
module tb_hilo_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned total;
    int unsigned passed;

    int unsigned wait_cycles;
    int unsigned busy_cycles;
    logic        held_ok;
    logic        saw_done;

    hilo_muldiv #(.n(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .in0      (in0),
        .in1      (in1),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Caller must be at a negedge; returns at the negedge after the sampling edge.
    task automatic pulse_start(input logic o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        in0   = a;
        in1   = b;
        @(negedge clk);
        start = 1'b0;
        op    = 1'b0;
        in0   = 32'hDEAD_BEEF;
        in1   = 32'hDEAD_BEEF;
    endtask

    // Waits (bounded) for done; counts negedges waited and busy cycles, checks hi/lo hold.
    task automatic wait_done(input logic [31:0] prev_hi, input logic [31:0] prev_lo);
        wait_cycles = 0;
        busy_cycles = 0;
        held_ok     = 1'b1;
        while (!done && wait_cycles < 100) begin
            if (busy) busy_cycles++;
            if (hi !== prev_hi || lo !== prev_lo) held_ok = 1'b0;
            @(negedge clk);
            wait_cycles++;
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        start  = 1'b0;
        op     = 1'b0;
        in0    = '0;
        in1    = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_dz", {63'd0, div_zero}, 64'd0);

        // Max multiply
        pulse_start(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(32'd0, 32'd0);
        check("mulmax_latency", 64'(wait_cycles), 64'd32);
        check("mulmax_busy", 64'(busy_cycles), 64'd32);
        check("mulmax_hold", {63'd0, held_ok}, 64'd1);
        check("mulmax_done_busy", {63'd0, busy}, 64'd0);
        check("mulmax_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        check("mulmax_done_pulse", {63'd0, done}, 64'd0);

        // Multiply by zero, started in the first IDLE cycle
        pulse_start(1'b0, 32'd12345, 32'd0);
        wait_done(32'hFFFF_FFFE, 32'h0000_0001);
        check("mulzero_latency", 64'(wait_cycles), 64'd32);
        check("mulzero_hilo", {hi, lo}, 64'd0);
        @(negedge clk);

        // Divide 100 / 7
        pulse_start(1'b1, 32'd100, 32'd7);
        wait_done(32'd0, 32'd0);
        check("div100_latency", 64'(wait_cycles), 64'd32);
        check("div100_busy", 64'(busy_cycles), 64'd32);
        check("div100_hilo", {hi, lo}, {32'd2, 32'd14});
        check("div100_dz", {63'd0, div_zero}, 64'd0);
        @(negedge clk);

        // Divide 5 / 9
        pulse_start(1'b1, 32'd5, 32'd9);
        wait_done(32'd2, 32'd14);
        check("div5_hold", {63'd0, held_ok}, 64'd1);
        check("div5_hilo", {hi, lo}, {32'd5, 32'd0});
        @(negedge clk);

        // Divide by zero: done in the very next cycle, busy never rises
        pulse_start(1'b1, 32'h0000_1234, 32'd0);
        check("dz_done", {63'd0, done}, 64'd1);
        check("dz_busy", {63'd0, busy}, 64'd0);
        check("dz_hilo", {hi, lo}, {32'h0000_1234, 32'hFFFF_FFFF});
        check("dz_flag", {63'd0, div_zero}, 64'd1);
        @(negedge clk);
        check("dz_done_pulse", {63'd0, done}, 64'd0);
        check("dz_flag_held", {63'd0, div_zero}, 64'd1);

        // Legal start clears div_zero; second start mid-operation is ignored
        pulse_start(1'b0, 32'd6, 32'd7);
        check("dz_cleared", {63'd0, div_zero}, 64'd0);
        repeat (4) @(negedge clk);
        pulse_start(1'b1, 32'd100, 32'd0);
        wait_done(32'h0000_1234, 32'hFFFF_FFFF);
        check("ign_latency", 64'(wait_cycles), 64'd27);
        check("ign_hold", {63'd0, held_ok}, 64'd1);
        check("ign_hilo", {hi, lo}, {32'd0, 32'd42});
        check("ign_dz", {63'd0, div_zero}, 64'd0);
        @(negedge clk);

        // Reset mid-divide, asserted between clock edges
        pulse_start(1'b1, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) saw_done = 1'b1;
            @(negedge clk);
        end
        check("midrst_quiet", {63'd0, saw_done}, 64'd0);

        // Fresh operation after the abort
        pulse_start(1'b1, 32'd1000, 32'd3);
        wait_done(32'd0, 32'd0);
        check("post_latency", 64'(wait_cycles), 64'd32);
        check("post_hilo", {hi, lo}, {32'd1, 32'd333});
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
